// File: rtl/instruction_decode.sv
// MIPS-32 decode stage: 2-entry skid buffer between fetch and execute,
// combinational field decode of the head entry and J/JAL redirect.
module instruction_decode #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [31:0]       id_imm,
    output logic              id_rtype,
    output logic              id_is_branch,
    output logic              id_is_jump,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc
);

    logic              r_main_v;
    logic [ADDR_W-1:0] r_main_pc;
    logic [DATA_W-1:0] r_main_instr;
    logic              r_skid_v;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [DATA_W-1:0] r_skid_instr;
    logic              r_redir_v;
    logic [ADDR_W-1:0] r_redir_pc;

    logic              w_acc;
    logic              w_fire;
    logic              w_in_jump;
    logic [3:0]        w_pc4_hi;
    logic [ADDR_W-1:0] w_target;
    logic [5:0]        w_op;
    logic [15:0]       w_imm16;

    assign if_ready = !r_skid_v;
    assign id_valid = r_main_v;
    assign w_acc    = if_valid && if_ready;
    assign w_fire   = r_main_v && id_ready;

    // Upper nibble of pc+4: carry into bit 28 only when pc[27:2] is all ones.
    assign w_pc4_hi  = if_pc[ADDR_W-1:ADDR_W-4] + {3'b000, &if_pc[ADDR_W-5:2]};
    assign w_target  = {w_pc4_hi, if_instr[25:0], 2'b00};
    assign w_in_jump = (if_instr[31:26] == 6'h02) || (if_instr[31:26] == 6'h03);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_v     <= 1'b0;
            r_main_pc    <= '0;
            r_main_instr <= '0;
            r_skid_v     <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_redir_v    <= 1'b0;
            r_redir_pc   <= '0;
        end else if (flush) begin
            r_main_v  <= 1'b0;
            r_skid_v  <= 1'b0;
            r_redir_v <= 1'b0;
        end else begin
            r_redir_v <= w_acc && w_in_jump;
            if (w_acc && w_in_jump) begin
                r_redir_pc <= w_target;
            end
            // Skid occupied means if_ready is low, so no accept can race it.
            if (r_skid_v) begin
                if (w_fire) begin
                    r_main_pc    <= r_skid_pc;
                    r_main_instr <= r_skid_instr;
                    r_skid_v     <= 1'b0;
                end
            end else if (w_acc) begin
                if (!r_main_v || w_fire) begin
                    r_main_v     <= 1'b1;
                    r_main_pc    <= if_pc;
                    r_main_instr <= if_instr;
                end else begin
                    r_skid_v     <= 1'b1;
                    r_skid_pc    <= if_pc;
                    r_skid_instr <= if_instr;
                end
            end else if (w_fire) begin
                r_main_v <= 1'b0;
            end
        end
    end

    assign w_op    = r_main_instr[31:26];
    assign w_imm16 = r_main_instr[15:0];

    assign id_pc     = r_main_pc;
    assign id_opcode = w_op;
    assign id_rs     = r_main_instr[25:21];
    assign id_rt     = r_main_instr[20:16];
    assign id_rd     = r_main_instr[15:11];
    assign id_shamt  = r_main_instr[10:6];
    assign id_funct  = r_main_instr[5:0];
    assign id_rtype  = (w_op == 6'h00);

    always_comb begin
        id_is_branch = 1'b0;
        id_is_jump   = 1'b0;
        id_imm       = {{16{w_imm16[15]}}, w_imm16};
        unique case (1'b1)
            (w_op == 6'h0C), (w_op == 6'h0D), (w_op == 6'h0E):
                id_imm = {16'h0000, w_imm16};
            (w_op == 6'h0F):
                id_imm = {w_imm16, 16'h0000};
            default: ;
        endcase
        unique case (1'b1)
            (w_op == 6'h01), (w_op == 6'h04), (w_op == 6'h05),
            (w_op == 6'h06), (w_op == 6'h07):
                id_is_branch = 1'b1;
            (w_op == 6'h02), (w_op == 6'h03):
                id_is_jump = 1'b1;
            default: ;
        endcase
    end

    assign redirect_valid = r_redir_v;
    assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed steps plus random traffic
// checked against a queue-based reference of the decode buffer.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [31:0] id_imm;
    logic        id_rtype;
    logic        id_is_branch;
    logic        id_is_jump;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic        m_rv;
    logic [31:0] m_rpc;

    always #5 clk = ~clk;

    instruction_decode #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm),
        .id_rtype(id_rtype), .id_is_branch(id_is_branch),
        .id_is_jump(id_is_jump),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int unsigned op  = ins >> 26;
        int unsigned v16 = ins & 32'hFFFF;
        if (op >= 12 && op <= 14) return v16;
        if (op == 15) return v16 * 65536;
        if (v16 >= 32768) return v16 + 32'hFFFF0000;
        return v16;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc,
                                               input logic [31:0] ins);
        logic [31:0] nxt = pc + 32'd4;
        return (nxt & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_rv  = 1'b0;
        m_rpc = '0;
    endtask

    // One cycle: check outputs against the reference, advance it, clock.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic rdy,
                        input logic fl);
        logic        e_rdy, e_val, acc, fire;
        int unsigned op;
        ent_t        h;
        if_valid = v; if_pc = pc; if_instr = ins;
        id_ready = rdy; flush = fl; rst = 1'b0;
        e_rdy = q.size() < 2;
        e_val = q.size() > 0;
        chk("if_ready", 32'(if_ready), 32'(e_rdy));
        chk("id_valid", 32'(id_valid), 32'(e_val));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        if (e_val) begin
            h  = q[0];
            op = h.instr >> 26;
            chk("id_pc", id_pc, h.pc);
            chk("id_opcode", 32'(id_opcode), op);
            chk("id_rs", 32'(id_rs), (h.instr >> 21) & 31);
            chk("id_rt", 32'(id_rt), (h.instr >> 16) & 31);
            chk("id_rd", 32'(id_rd), (h.instr >> 11) & 31);
            chk("id_shamt", 32'(id_shamt), (h.instr >> 6) & 31);
            chk("id_funct", 32'(id_funct), h.instr & 63);
            chk("id_imm", id_imm, ref_imm(h.instr));
            chk("id_rtype", 32'(id_rtype), 32'(op == 0));
            chk("id_is_branch", 32'(id_is_branch),
                32'(op == 1 || (op >= 4 && op <= 7)));
            chk("id_is_jump", 32'(id_is_jump), 32'(op == 2 || op == 3));
        end
        acc  = v && e_rdy;
        fire = e_val && rdy;
        op   = ins >> 26;
        if (fl) begin
            q.delete();
            m_rv = 1'b0;
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc, instr: ins});
            m_rv = acc && (op == 2 || op == 3);
            if (m_rv) m_rpc = ref_target(pc, ins);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        if_pc = '0; if_instr = '0;
        do_reset(2);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_imm", id_imm, 32'd0);

        // Immediate forms back-to-back with execute always ready.
        step(1'b1, 32'h0, 32'h2008FFFF, 1'b1, 1'b0);
        chk("t2_imm_addi", id_imm, 32'hFFFFFFFF);
        step(1'b1, 32'h4, 32'h3408FFFF, 1'b1, 1'b0);
        chk("t2_imm_ori", id_imm, 32'h0000FFFF);
        step(1'b1, 32'h8, 32'h3C011234, 1'b1, 1'b0);
        chk("t2_imm_lui", id_imm, 32'h12340000);
        chk("t2_rt_lui", 32'(id_rt), 32'd1);
        step(1'b1, 32'hC, 32'h01095020, 1'b1, 1'b0);
        chk("t3_rtype", 32'(id_rtype), 32'd1);
        chk("t3_rd", 32'(id_rd), 32'd10);
        chk("t3_funct", 32'(id_funct), 32'h20);
        idle(1'b1);

        // Backpressure: two entries fill, third held until release.
        step(1'b1, 32'h0, 32'h20010001, 1'b0, 1'b0);
        step(1'b1, 32'h4, 32'h20020002, 1'b0, 1'b0);
        chk("t4_if_ready_low", 32'(if_ready), 32'd0);
        step(1'b1, 32'h8, 32'h20030003, 1'b0, 1'b0);
        step(1'b1, 32'h8, 32'h20030003, 1'b1, 1'b0);
        chk("t4_second_pc", id_pc, 32'h4);
        step(1'b1, 32'h8, 32'h20030003, 1'b1, 1'b0);
        chk("t4_third_pc", id_pc, 32'h8);
        idle(1'b1);

        // Jump redirect, delay slot kept, then jump killed by flush.
        step(1'b1, 32'h00400020, 32'h08000010, 1'b1, 1'b0);
        chk("t5_redir_v", 32'(redirect_valid), 32'd1);
        chk("t5_redir_pc", redirect_pc, 32'h00000040);
        step(1'b1, 32'h00400024, 32'h00000000, 1'b1, 1'b0);
        chk("t5_redir_pulse", 32'(redirect_valid), 32'd0);
        chk("t5_delay_slot", id_pc, 32'h00400024);
        step(1'b1, 32'h00400020, 32'h08000010, 1'b1, 1'b1);
        chk("t5_flush_no_redir", 32'(redirect_valid), 32'd0);
        step(1'b1, 32'h0FFFFFFC, 32'h0C000001, 1'b1, 1'b0);
        chk("t5_carry_target", redirect_pc, 32'h10000004);
        step(1'b1, 32'hFFFFFFFC, 32'h0BFFFFFF, 1'b1, 1'b0);
        chk("t5_wrap_target", redirect_pc, 32'h0FFFFFFC);
        idle(1'b1);

        // Flush with both entries full and input presented.
        step(1'b1, 32'h100, 32'h24040004, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'h24050005, 1'b0, 1'b0);
        step(1'b1, 32'h108, 32'h24060006, 1'b0, 1'b1);
        chk("t6_flush_valid", 32'(id_valid), 32'd0);
        chk("t6_flush_ready", 32'(if_ready), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Mid-stream reset with a jump redirect pending.
        step(1'b1, 32'h200, 32'h20070007, 1'b0, 1'b0);
        if_valid = 1'b1; if_pc = 32'h204; if_instr = 32'h08000100;
        do_reset(2);
        chk("t1_id_valid", 32'(id_valid), 32'd0);
        chk("t1_if_ready", 32'(if_ready), 32'd1);
        chk("t1_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("t1_id_pc", id_pc, 32'd0);

        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) == 0)
                ins[31:26] = 6'($urandom_range(0, 15));
            pc = $urandom;
            step($urandom_range(0, 3) != 0, pc, ins,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
